// File: rtl/fp_add_sub_unit.sv
// Binary32 add/sub: round-to-nearest-even, flush-to-zero, registered result.
// Define FP_ADDSUB_FLAGS_EN to add flags[3:0] = {invalid, overflow, underflow, inexact}.
module fp_add_sub_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Cin,
  input  logic [2:0]  opcode,
`ifdef FP_ADDSUB_FLAGS_EN
  output logic [3:0]  flags,
`endif
  output logic [31:0] Out
);

  localparam logic [31:0] QNAN = 32'h7FC00000;

  logic        unused_cin;
  logic        sub_op;
  logic        sa, sb;
  logic [7:0]  ea, eb;
  logic [22:0] fa, fb;
  logic        a_nan, b_nan;
  logic        a_inf, b_inf;
  logic        a_zero, b_zero;
  logic [23:0] ma, mb;
  logic        swap;
  logic        sl, ss;
  logic [7:0]  el, es;
  logic [23:0] ml, ms;
  logic [7:0]  ediff;
  logic [49:0] sh_ext;
  logic [26:0] al_l, al_s;
  logic        eff_sub;
  logic [27:0] sum;
  logic [26:0] dif;
  logic [4:0]  lz;
  logic [26:0] nrm;
  logic [9:0]  exp_n, exp_r;
  logic        rnd_up;
  logic [24:0] rnd;
  logic [22:0] frac_r;
  logic        ovf, unf;
  logic [31:0] res;
`ifdef FP_ADDSUB_FLAGS_EN
  logic [3:0]  flg;
`endif

  function automatic logic [4:0] lead_zeros(
    input logic [26:0] v
  );
    logic [4:0] n;
    n = 5'd0;
    for (int i = 0; i < 27; i++)
      if (v[i]) n = 5'(26 - i);
    return n;
  endfunction

  assign unused_cin = Cin;
  assign sub_op = (opcode == 3'b001);

  assign sa = A[31];
  assign ea = A[30:23];
  assign fa = A[22:0];
  assign sb = B[31] ^ sub_op;
  assign eb = B[30:23];
  assign fb = B[22:0];

  assign a_zero = (ea == 8'd0);
  assign b_zero = (eb == 8'd0);
  assign a_nan  = (ea == 8'hFF) && (fa != 23'd0);
  assign b_nan  = (eb == 8'hFF) && (fb != 23'd0);
  assign a_inf  = (ea == 8'hFF) && (fa == 23'd0);
  assign b_inf  = (eb == 8'hFF) && (fb == 23'd0);

  assign ma = a_zero ? 24'd0 : {1'b1, fa};
  assign mb = b_zero ? 24'd0 : {1'b1, fb};

  // Exponent then significand: one wide compare orders magnitudes
  assign swap = {eb, mb} > {ea, ma};
  assign sl = swap ? sb : sa;
  assign ss = swap ? sa : sb;
  assign el = swap ? eb : ea;
  assign es = swap ? ea : eb;
  assign ml = swap ? mb : ma;
  assign ms = swap ? ma : mb;

  assign ediff  = el - es;
  assign sh_ext = {ms, 26'd0} >> ediff;
  assign al_l   = {ml, 3'b000};
  assign al_s   = (ediff >= 8'd26)
                ? {26'd0, |ms}
                : {sh_ext[49:24], |sh_ext[23:0]};

  assign eff_sub = sl ^ ss;
  assign sum = {1'b0, al_l} + {1'b0, al_s};
  assign dif = al_l - al_s;
  assign lz  = lead_zeros(dif);

  always_comb begin
    nrm   = sum[26:0];
    exp_n = {2'b00, el};
    if (!eff_sub) begin
      if (sum[27]) begin
        nrm   = {sum[27:2], sum[1] | sum[0]};
        exp_n = {2'b00, el} + 10'd1;
      end
    end else begin
      nrm   = dif << lz;
      exp_n = {2'b00, el} - {5'd0, lz};
    end
  end

  assign rnd_up = nrm[2] & (nrm[1] | nrm[0] | nrm[3]);
  assign rnd    = {1'b0, nrm[26:3]} + {24'd0, rnd_up};
  assign exp_r  = rnd[24] ? exp_n + 10'd1 : exp_n;
  assign frac_r = rnd[24] ? rnd[23:1] : rnd[22:0];

  // exp_r is two's complement; bit 9 flags a negative exponent
  assign ovf = !exp_r[9] && (exp_r >= 10'd255);
  assign unf = exp_r[9] || (exp_r == 10'd0);

  always_comb begin
    res = {sl, exp_r[7:0], frac_r};
`ifdef FP_ADDSUB_FLAGS_EN
    flg = {3'b000, |nrm[2:0]};
`endif
    if (a_nan || b_nan) begin
      res = QNAN;
`ifdef FP_ADDSUB_FLAGS_EN
      flg = 4'b1000;
`endif
    end else if (a_inf && b_inf && (sa ^ sb)) begin
      res = QNAN;
`ifdef FP_ADDSUB_FLAGS_EN
      flg = 4'b1000;
`endif
    end else if (a_inf || b_inf) begin
      res = {a_inf ? sa : sb, 8'hFF, 23'd0};
`ifdef FP_ADDSUB_FLAGS_EN
      flg = 4'b0000;
`endif
    end else if (a_zero && b_zero) begin
      res = {sa & sb, 31'd0};
`ifdef FP_ADDSUB_FLAGS_EN
      flg = 4'b0000;
`endif
    end else if (eff_sub && (dif == 27'd0)) begin
      res = 32'd0;
`ifdef FP_ADDSUB_FLAGS_EN
      flg = 4'b0000;
`endif
    end else if (ovf) begin
      res = {sl, 8'hFF, 23'd0};
`ifdef FP_ADDSUB_FLAGS_EN
      flg = 4'b0101;
`endif
    end else if (unf) begin
      res = {sl, 31'd0};
`ifdef FP_ADDSUB_FLAGS_EN
      flg = 4'b0011;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) Out <= 32'd0;
    else        Out <= res;
  end

`ifdef FP_ADDSUB_FLAGS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flags <= 4'b0000;
    else        flags <= flg;
  end
`endif

endmodule

// File: tb/tb_fp_add_sub_unit.sv
// Directed bench for fp_add_sub_unit.
// Expected results are queued at drive time and compared after the edge.
module tb_fp_add_sub_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] A, B, Out;
  logic        Cin;
  logic [2:0]  opcode;
`ifdef FP_ADDSUB_FLAGS_EN
  logic [3:0]  flags;
`endif

  int passed = 0;
  int total  = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  fp_add_sub_unit dut (
    .clk(clk),
    .rst_n(rst_n),
    .A(A),
    .B(B),
    .Cin(Cin),
    .opcode(opcode),
`ifdef FP_ADDSUB_FLAGS_EN
    .flags(flags),
`endif
    .Out(Out)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h",
                tag, obs, exp);
  endtask

  task automatic drive(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [2:0]  op,
    input logic        ci,
    input logic [31:0] e,
    input string       tag
  );
    A = a;
    B = b;
    opcode = op;
    Cin = ci;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic collect();
    logic [31:0] e;
    string t;
    if (exp_q.size() == 0) begin
      total++;
      $error("FAIL scoreboard_empty: observed %h expected a queued result",
             Out);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check(t, Out, e);
    end
  endtask

  task automatic step(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [2:0]  op,
    input logic        ci,
    input logic [31:0] e,
    input string       tag
  );
    @(negedge clk);
    drive(a, b, op, ci, e, tag);
    @(posedge clk);
    #1 collect();
  endtask

  initial begin
    rst_n  = 1'b1;
    A      = 32'h12345678;
    B      = 32'h9ABCDEF0;
    Cin    = 1'b0;
    opcode = 3'b000;

    #2 rst_n = 1'b0;
    #1 check("rst_async", Out, 32'h0);
    repeat (2) @(posedge clk);
    #1 check("rst_hold", Out, 32'h0);
`ifdef FP_ADDSUB_FLAGS_EN
    check("rst_flags", {28'd0, flags}, 32'h0);
`endif

    @(negedge clk);
    A = 32'h0;
    B = 32'h0;
    rst_n = 1'b1;
    #1 check("rst_release", Out, 32'h0);
    @(posedge clk);
    #1 check("first_zero_op", Out, 32'h0);

    step(32'h41360000, 32'h40B20419, 3'b000, 1'b0,
         32'h41878106, "add_pos");
    step(32'hC1360000, 32'hC0B20419, 3'b000, 1'b0,
         32'hC1878106, "add_neg");
    step(32'h41360000, 32'hC0B20419, 3'b000, 1'b0,
         32'h40B9FBE7, "mixed_pn");
    step(32'hC1360000, 32'h40B20419, 3'b000, 1'b0,
         32'hC0B9FBE7, "mixed_np");
    step(32'h41360000, 32'h40B20419, 3'b001, 1'b0,
         32'h40B9FBE7, "sub");
    step(32'h41360000, 32'h40B20419, 3'b111, 1'b0,
         32'h41878106, "op111_add");
    step(32'h41360000, 32'h40B20419, 3'b001, 1'b1,
         32'h40B9FBE7, "sub_cin1");
    step(32'h41360000, 32'h40B20419, 3'b111, 1'b1,
         32'h41878106, "op111_cin1");

    step(32'h7F800000, 32'hFF800000, 3'b000, 1'b0,
         32'h7FC00000, "inf_minus_inf");
`ifdef FP_ADDSUB_FLAGS_EN
    check("flags_invalid", {28'd0, flags}, 32'h8);
`endif
    step(32'h7F800000, 32'h7F800000, 3'b001, 1'b0,
         32'h7FC00000, "inf_sub_inf");
    step(32'h7FC00001, 32'h3F800000, 3'b000, 1'b0,
         32'h7FC00000, "nan_in");
    step(32'hFF800000, 32'h3F800000, 3'b000, 1'b0,
         32'hFF800000, "inf_plus_fin");
    step(32'h7F7FFFFF, 32'h7F7FFFFF, 3'b000, 1'b0,
         32'h7F800000, "ovf_pos");
`ifdef FP_ADDSUB_FLAGS_EN
    check("flags_ovf", {28'd0, flags}, 32'h5);
`endif
    step(32'hFF7FFFFF, 32'hFF7FFFFF, 3'b000, 1'b0,
         32'hFF800000, "ovf_neg");
    step(32'h41360000, 32'h41360000, 3'b001, 1'b0,
         32'h00000000, "cancel");
    step(32'h00400000, 32'h3F800000, 3'b000, 1'b0,
         32'h3F800000, "subnorm_ftz");
    step(32'h80000000, 32'h80000000, 3'b000, 1'b0,
         32'h80000000, "negz_negz");
    step(32'h00000000, 32'h80000000, 3'b000, 1'b0,
         32'h00000000, "posz_negz");
    step(32'h00800001, 32'h00800000, 3'b001, 1'b0,
         32'h00000000, "unf_pos");
`ifdef FP_ADDSUB_FLAGS_EN
    check("flags_unf", {28'd0, flags}, 32'h3);
`endif
    step(32'h80800001, 32'h80800000, 3'b001, 1'b0,
         32'h80000000, "unf_neg");
    step(32'h3F800000, 32'h33800000, 3'b000, 1'b0,
         32'h3F800000, "tie_even_down");
    step(32'h3F800001, 32'h33800000, 3'b000, 1'b0,
         32'h3F800002, "tie_odd_up");
`ifdef FP_ADDSUB_FLAGS_EN
    check("flags_inexact", {28'd0, flags}, 32'h1);
`endif
    step(32'h4B800000, 32'h3F800000, 3'b000, 1'b0,
         32'h4B800000, "d24_tie");
    step(32'h4B800000, 32'h3F800001, 3'b000, 1'b0,
         32'h4B800001, "d24_sticky");
    step(32'h4C800000, 32'h3F800000, 3'b000, 1'b0,
         32'h4C800000, "d26_sticky");

    step(32'h3F800000, 32'h3F800000, 3'b000, 1'b0,
         32'h40000000, "one_plus_one");
    #2 rst_n = 1'b0;
    #1 check("mid_rst_async", Out, 32'h0);
    @(posedge clk);
    #1 check("mid_rst_hold", Out, 32'h0);
    exp_q.delete();
    tag_q.delete();

    @(negedge clk);
    rst_n = 1'b1;
    drive(32'hC1360000, 32'h40B20419, 3'b000, 1'b0,
          32'hC0B9FBE7, "post_rst");
    @(posedge clk);
    #1 collect();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fp_add_sub_unit.md
Name: fp_add_sub_unit

Overview:
- Single-precision IEEE-754 floating-point adder/subtractor with a registered result.
- Sits in the FP datapath as the add/sub execution unit.
- Takes two binary32 operands and an opcode selecting A+B or A−B.
- Produces a rounded binary32 result one clock after the operands are sampled.

Parameters:
- None. Format is fixed binary32: 1 sign bit, 8 exponent bits (bias 127), 23 fraction bits.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- A  input  32  operand A, binary32.
- B  input  32  operand B, binary32.
- Cin  input  1  reserved carry-in; functionally ignored; drive 0.
- opcode  input  3  3'b000 = A+B, 3'b001 = A−B; all other codes behave as A+B.
- Out  output  32  registered binary32 result.

Behaviour:
- Reset: one clock, asynchronous active-low reset. rst_n low forces Out = 32'h00000000 immediately, independent of clk. Out holds 0 until the first rising edge after rst_n deasserts.
- Latency: 1 cycle. Out at edge N+1 equals f(A, B, opcode) sampled at edge N. A new operation is accepted every cycle. No handshake.
- Subtract: invert B's sign, then perform the addition path.
- Datapath:
  - Unpack operands, with the hidden 1 for normals.
  - Swap so the larger magnitude is first. Compare exponent, then significand.
  - Align the smaller significand right by the exponent difference. Keep guard, round and sticky bits; differences ≥ 26 collapse into sticky.
  - Effective add (signs equal): add significands. On carry-out, shift right 1 and increment the exponent; the shifted-out bit feeds the GRS bits.
  - Effective subtract: subtract the smaller from the larger; result sign is the larger operand's sign. Normalise left with a leading-zero count, decrementing the exponent.
  - Rounding: round-to-nearest-even. Round up when G & (R | S | LSB). A rounding carry renormalises and increments the exponent.
- Subnormals: flush-to-zero. Inputs with exp == 0 are treated as signed zero. Results with exponent ≤ 0 become signed zero (sign of the computed result).
- Special cases (priority order):
  - Any NaN input → 32'h7FC00000.
  - +Inf plus −Inf (after opcode sign flip) → 32'h7FC00000.
  - Inf plus finite → that Inf.
  - Result exponent ≥ 255 → ±Inf (32'h7F800000 / 32'hFF800000).
  - Exact cancellation to zero → +0.
  - −0 + −0 → −0 (32'h80000000).
  - Zero plus x → x.
- Cin, X-free: Cin has no effect on Out for any value.

Optional Feature:
- Macro FP_ADDSUB_FLAGS_EN.
- Defined:
  - Adds output port flags [3:0] = {invalid, overflow, underflow, inexact}, registered alongside Out, reset to 4'b0000.
  - invalid: NaN produced from Inf−Inf or from a NaN input.
  - overflow: Inf produced from finite inputs.
  - underflow: nonzero result flushed to zero.
  - inexact: any nonzero GRS before rounding, or overflow/underflow.
- Undefined: the flags port and its logic are absent; Out behaviour is identical.

Test Plan:
- Reset: hold rst_n=0 with arbitrary A/B → Out=32'h00000000 asynchronously. Release; first result appears one edge after the first sampled operands.
- Add, opcode=000:
  - A=32'h41360000 (11.375), B=32'h40B20419 (5.563) → Out=32'h41878106 (16.938) one cycle later.
  - A=32'hC1360000, B=32'hC0B20419 → Out=32'hC1878106.
- Mixed signs, opcode=000:
  - A=32'h41360000, B=32'hC0B20419 → Out=32'h40B9FBE7 (5.812).
  - A=32'hC1360000, B=32'h40B20419 → Out=32'hC0B9FBE7.
- Subtract, opcode=001:
  - A=32'h41360000, B=32'h40B20419 → Out=32'h40B9FBE7.
  - Same operands with opcode=111 → Out=32'h41878106.
  - Repeat with Cin=1 → identical results.
- Specials:
  - 32'h7F800000 + 32'hFF800000 → 32'h7FC00000.
  - 32'h7F7FFFFF + 32'h7F7FFFFF → 32'h7F800000.
  - 32'h41360000 − 32'h41360000 → 32'h00000000.
  - 32'h00400000 (subnormal) + 32'h3F800000 → 32'h3F800000.
- Back-to-back and mid-operation reset: change operands every cycle → each Out matches the previous cycle's operands. Assert rst_n low between edges → Out=0 immediately, with no stale result after release.
